// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared widths and the fetch FIFO entry type used by the
//               instruction fetch front end (fetch_unit, fetch_fifo).
//               INST_W : instruction width (bit 9 op select, bits 8:0 Rw/Ra/Rb)
//               PC_W   : PC / instruction memory address width
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int INST_W = 10;
    localparam int PC_W   = 8;

    // One buffered instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
    } fetch_entry_t;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous FIFO of fetch_entry_t with clear, occupancy count
//               and a combinational head view. Pointers wrap modulo DEPTH.
// Ports       : clk      - clock, rising edge
//               rst      - asynchronous active-high reset
//               i_clear  - drop all entries (wins over push/pop)
//               i_push   - write i_entry at the tail
//               i_entry  - entry to write
//               i_pop    - advance the head
//               o_count  - number of valid entries (0..DEPTH)
//               o_head   - entry at the head (meaningful when o_count != 0)
// Parameters  : DEPTH    - number of entries, power of two, >= 2
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_clear,
    input  logic                       i_push,
    input  fetch_entry_t               i_entry,
    input  logic                       i_pop,
    output logic [$clog2(DEPTH):0]     o_count,
    output fetch_entry_t               o_head
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t    r_mem [DEPTH];
    logic [AW-1:0]   r_rd;
    logic [AW-1:0]   r_wr;
    logic [AW:0]     r_count;

    // Storage is reset as well so the head reads as zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_clear) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr] <= i_entry;
                r_wr        <= r_wr + 1'b1;
            end
            if (i_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd];

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch front end. Issues sequential PCs to a
//               synchronous instruction memory (1-cycle read latency),
//               buffers returned instructions in a small FIFO and presents
//               one instruction per cycle to the decoder with a valid/stall
//               handshake. Supports redirect (flush) and end-of-program stop.
//               Optional macro FETCH_BYPASS_EN: a response arriving while the
//               FIFO is empty is shown on inst/inst_pc in the same cycle.
// Ports       : clk        - clock, rising edge
//               rst        - asynchronous active-high reset
//               stall      - downstream not ready, head is held
//               flush      - redirect request (sampled at the clock edge)
//               flush_pc   - redirect target
//               imem_addr  - instruction memory read address
//               imem_en    - read request, data returned next cycle
//               imem_data  - read data, valid one cycle after imem_en
//               inst       - head instruction to the decoder
//               inst_pc    - PC of the head instruction
//               valid_pc   - inst/inst_pc valid
//               done       - program exhausted, FIFO empty, nothing in flight
// Parameters  : DEPTH      - fetch FIFO entries (power of two, >= 2)
//               PROG_LEN   - number of valid instructions
//               (INST_W and PC_W come from fetch_pkg)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int PROG_LEN = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic [PC_W-1:0]   flush_pc,
    output logic [PC_W-1:0]   imem_addr,
    output logic              imem_en,
    input  logic [INST_W-1:0] imem_data,
    output logic [INST_W-1:0] inst,
    output logic [PC_W-1:0]   inst_pc,
    output logic              valid_pc,
    output logic              done
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0]   c_DEPTH    = (CW+1)'(DEPTH);
    localparam logic [PC_W:0] c_PROG_LEN = (PC_W+1)'(PROG_LEN);

    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_issue_pc;   // PC of the read currently in flight
    logic            r_inflight;

    logic [CW-1:0]   w_count;
    fetch_entry_t    w_head;
    fetch_entry_t    w_push_entry;
    logic            w_byp;
    logic            w_valid;
    logic            w_pop;
    logic            w_fifo_pop;
    logic            w_push;
    logic            w_pc_ok;
    logic            w_credit_ok;
    logic            w_issue;

`ifdef FETCH_BYPASS_EN
    assign w_byp = r_inflight && (w_count == '0);
`else
    assign w_byp = 1'b0;
`endif

    assign w_valid    = (w_count != '0) || w_byp;
    assign w_pop      = w_valid && !stall;
    // A bypassed response never occupies the FIFO, so nothing to pop there.
    assign w_fifo_pop = w_pop && !w_byp;
    // A bypassed response consumed this cycle is not written; a stalled one is.
    assign w_push     = r_inflight && !(w_byp && !stall);

    // Credit check: entries held plus the read in flight, less this cycle's
    // pop, must leave room for one more response. Written as an addition on
    // the right-hand side to stay unsigned.
    assign w_credit_ok = ({1'b0, w_count} + {{CW{1'b0}}, r_inflight})
                         < (c_DEPTH + {{CW{1'b0}}, w_pop});
    assign w_pc_ok     = {1'b0, r_pc} < c_PROG_LEN;
    // Reset is asynchronous, so the request is also masked while it is held.
    assign w_issue     = !rst && !flush && w_pc_ok && w_credit_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= '0;
            r_issue_pc <= '0;
            r_inflight <= 1'b0;
        end else if (flush) begin
            // Clearing inflight drops the response that arrives next cycle.
            r_pc       <= flush_pc;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_pc       <= r_pc + 1'b1;
                r_issue_pc <= r_pc;
            end
        end
    end

    assign w_push_entry = '{inst: imem_data, pc: r_issue_pc};

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_clear (flush),
        .i_push  (w_push),
        .i_entry (w_push_entry),
        .i_pop   (w_fifo_pop),
        .o_count (w_count),
        .o_head  (w_head)
    );

    assign imem_en   = w_issue;
    assign imem_addr = r_pc;
    assign valid_pc  = w_valid;
    assign inst      = w_byp ? imem_data  : w_head.inst;
    assign inst_pc   = w_byp ? r_issue_pc : w_head.pc;
    assign done      = !w_pc_ok && (w_count == '0) && !r_inflight;

endmodule : fetch_unit
`default_nettype wire
